// File: rtl/host_game_ctrl.sv
// Host-side hangman sequencer: collects the secret word, scores radio guesses,
// and drives the host display status lines.
module host_game_ctrl #(
    parameter int unsigned MAX_MISS = 6,
    parameter int unsigned END_HOLD = 100
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        key_valid,
    input  logic [7:0]  key_letter,
    input  logic        key_submit,
    input  logic        rx_valid,
    input  logic [7:0]  rx_letter,
    input  logic        restart,
    output logic        ready,
    output logic [7:0]  setLetter,
    output logic [39:0] temp_word,
    output logic        toggle_state,
    output logic [7:0]  letter,
    output logic [4:0]  indexCorrect,
    output logic [2:0]  correct,
    output logic [2:0]  incorrect,
    output logic        mistake,
    output logic        dup,
    output logic        gameEnd_host
);

    localparam logic [7:0]  Blank     = 8'h5F;
    localparam logic [39:0] BlankWord = {5{Blank}};
    localparam int unsigned HoldW     = (END_HOLD > 1) ? $clog2(END_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldLast = HoldW'(END_HOLD - 1);
    localparam logic [2:0]  MissLimit = 3'(MAX_MISS);

    typedef enum logic [2:0] {StSetup, StPlay, StCheck, StWin, StLose} state_e;

    state_e           state;
    logic [2:0]       key_cnt;
    logic [4:0]       revealed;
    logic [25:0]      guessed;
    logic [HoldW-1:0] hold_cnt;

    logic [7:0] key_up, rx_up, guess_off;
    logic       key_ok, rx_ok, already, end_round;
    logic [4:0] match;
    logic [2:0] gain, new_correct, new_incorrect;

    // Fold lowercase ASCII to uppercase; other values pass unchanged.
    function automatic logic [7:0] fold(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? (c & 8'hDF) : c;
    endfunction

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5A);
    endfunction

    // Letter validation and scoring of the guess held in `letter`.
    always_comb begin
        key_up        = fold(key_letter);
        key_ok        = is_letter(key_up);
        rx_up         = fold(rx_letter);
        rx_ok         = is_letter(rx_up);
        guess_off     = letter - 8'h41;
        already       = guessed[guess_off[4:0]];
        gain          = '0;
        match         = '0;
        for (int i = 0; i < 5; i++) begin
            match[i] = (temp_word[i*8 +: 8] == letter);
            if (match[i] && !revealed[i]) begin
                gain = gain + 3'd1;
            end
        end
        new_correct   = correct + gain;
        new_incorrect = incorrect + 3'd1;
        // Restart wins over everything, including a pending CHECK result.
        end_round     = restart ||
                        (((state == StWin) || (state == StLose)) && (hold_cnt == HoldLast));
    end

    // Game FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state        <= StSetup;
            key_cnt      <= '0;
            revealed     <= '0;
            guessed      <= '0;
            hold_cnt     <= '0;
            ready        <= 1'b0;
            setLetter    <= Blank;
            temp_word    <= BlankWord;
            toggle_state <= 1'b0;
            letter       <= Blank;
            indexCorrect <= '0;
            correct      <= '0;
            incorrect    <= '0;
            mistake      <= 1'b0;
            dup          <= 1'b0;
            gameEnd_host <= 1'b0;
        end else begin
            toggle_state <= 1'b0;
            dup          <= 1'b0;
            gameEnd_host <= 1'b0;
            if (end_round) begin
                gameEnd_host <= 1'b1;
                state        <= StSetup;
                key_cnt      <= '0;
                revealed     <= '0;
                guessed      <= '0;
                hold_cnt     <= '0;
                ready        <= 1'b0;
                setLetter    <= Blank;
                temp_word    <= BlankWord;
                letter       <= Blank;
                indexCorrect <= '0;
                correct      <= '0;
                incorrect    <= '0;
                mistake      <= 1'b0;
            end else begin
                unique case (state)
                    StSetup: begin
                        if (key_valid && key_ok && (key_cnt != 3'd5)) begin
                            unique case (key_cnt)
                                3'd0:    temp_word[39:32] <= key_up;
                                3'd1:    temp_word[31:24] <= key_up;
                                3'd2:    temp_word[23:16] <= key_up;
                                3'd3:    temp_word[15:8]  <= key_up;
                                default: temp_word[7:0]   <= key_up;
                            endcase
                            setLetter <= key_up;
                            key_cnt   <= key_cnt + 3'd1;
                        end
                        if (key_submit && (key_cnt == 3'd5)) begin
                            toggle_state <= 1'b1;
                            ready        <= 1'b1;
                            state        <= StPlay;
                        end
                    end
                    StPlay: begin
                        if (rx_valid && rx_ok) begin
                            letter <= rx_up;
                            ready  <= 1'b0;
                            state  <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (already) begin
                            indexCorrect <= '0;
                            mistake      <= 1'b0;
                            dup          <= 1'b1;
                            ready        <= 1'b1;
                            state        <= StPlay;
                        end else begin
                            guessed[guess_off[4:0]] <= 1'b1;
                            indexCorrect            <= match;
                            if (|match) begin
                                mistake  <= 1'b0;
                                correct  <= new_correct;
                                revealed <= revealed | match;
                            end else begin
                                mistake   <= 1'b1;
                                incorrect <= new_incorrect;
                            end
                            hold_cnt <= '0;
                            if ((|match) && (new_correct == 3'd5)) begin
                                state <= StWin;
                            end else if (!(|match) && (new_incorrect == MissLimit)) begin
                                state <= StLose;
                            end else begin
                                ready <= 1'b1;
                                state <= StPlay;
                            end
                        end
                    end
                    StWin, StLose: begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    default: state <= StSetup;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_host_game_ctrl.sv
// Directed self-checking bench for host_game_ctrl.
module tb_host_game_ctrl;

    localparam int unsigned MAX_MISS = 6;
    localparam int unsigned END_HOLD = 5;

    logic        clk, nRst;
    logic        key_valid, key_submit, rx_valid, restart;
    logic [7:0]  key_letter, rx_letter;
    logic        ready, toggle_state, mistake, dup, gameEnd_host;
    logic [7:0]  setLetter, letter;
    logic [39:0] temp_word;
    logic [4:0]  indexCorrect;
    logic [2:0]  correct, incorrect;

    int n_checks = 0;
    int n_fail   = 0;

    host_game_ctrl #(.MAX_MISS(MAX_MISS), .END_HOLD(END_HOLD)) dut (
        .clk(clk), .nRst(nRst),
        .key_valid(key_valid), .key_letter(key_letter), .key_submit(key_submit),
        .rx_valid(rx_valid), .rx_letter(rx_letter), .restart(restart),
        .ready(ready), .setLetter(setLetter), .temp_word(temp_word),
        .toggle_state(toggle_state), .letter(letter), .indexCorrect(indexCorrect),
        .correct(correct), .incorrect(incorrect), .mistake(mistake), .dup(dup),
        .gameEnd_host(gameEnd_host)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_key(input logic [7:0] c);
        key_letter = c;
        key_valid  = 1'b1;
        step();
        key_valid  = 1'b0;
    endtask

    task automatic send_submit();
        key_submit = 1'b1;
        step();
        key_submit = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] c);
        rx_letter = c;
        rx_valid  = 1'b1;
        step();
        rx_valid  = 1'b0;
    endtask

    // Guess lands in CHECK after one edge; results appear after the next.
    task automatic guess(input logic [7:0] c);
        send_rx(c);
        step();
    endtask

    task automatic load_word(input logic [39:0] w);
        for (int i = 0; i < 5; i++) send_key(w[39-8*i -: 8]);
    endtask

    task automatic test_reset();
        n_checks++; if (temp_word !== 40'h5F5F5F5F5F) begin n_fail++;
            $display("FAIL reset_temp_word got %h want 5f5f5f5f5f", temp_word); end
        n_checks++; if (setLetter !== 8'h5F) begin n_fail++;
            $display("FAIL reset_setLetter got %h want 5f", setLetter); end
        n_checks++; if (letter !== 8'h5F) begin n_fail++;
            $display("FAIL reset_letter got %h want 5f", letter); end
        n_checks++;
        if ({indexCorrect, correct, incorrect, mistake, dup, toggle_state, gameEnd_host, ready}
            !== 16'h0) begin n_fail++;
            $display("FAIL reset_status got %b want 0", {indexCorrect, correct, incorrect,
                     mistake, dup, toggle_state, gameEnd_host, ready}); end
    endtask

    task automatic test_setup();
        send_rx(8'h61);
        n_checks++; if (letter !== 8'h5F) begin n_fail++;
            $display("FAIL setup_rx_ignored got %h want 5f", letter); end
        send_key(8'h37);
        send_key(8'h20);
        n_checks++; if (setLetter !== 8'h5F || temp_word !== 40'h5F5F5F5F5F) begin n_fail++;
            $display("FAIL setup_bad_keys got %h/%h want 5f", setLetter, temp_word); end
        send_key(8'h68); send_key(8'h65); send_key(8'h6C);
        n_checks++; if (temp_word !== 40'h48454C5F5F || setLetter !== 8'h4C) begin n_fail++;
            $display("FAIL setup_three got %h/%h want 48454c5f5f/4c", temp_word, setLetter); end
        send_submit();
        n_checks++; if (toggle_state !== 1'b0 || ready !== 1'b0) begin n_fail++;
            $display("FAIL early_submit got tog=%b rdy=%b want 0/0", toggle_state, ready); end
        send_key(8'h6C); send_key(8'h6F);
        send_key(8'h78);
        n_checks++; if (temp_word !== 40'h48454C4C4F || setLetter !== 8'h4F) begin n_fail++;
            $display("FAIL setup_word got %h/%h want 48454c4c4f/4f", temp_word, setLetter); end
        send_submit();
        n_checks++; if (toggle_state !== 1'b1) begin n_fail++;
            $display("FAIL toggle_pulse got %b want 1", toggle_state); end
        step();
        n_checks++; if (toggle_state !== 1'b0 || ready !== 1'b1) begin n_fail++;
            $display("FAIL toggle_end got tog=%b rdy=%b want 0/1", toggle_state, ready); end
    endtask

    task automatic test_play();
        send_key(8'h41);
        n_checks++; if (setLetter !== 8'h4F) begin n_fail++;
            $display("FAIL play_key_ignored got %h want 4f", setLetter); end
        send_rx(8'h37);
        n_checks++; if (ready !== 1'b1 || letter !== 8'h5F) begin n_fail++;
            $display("FAIL play_bad_rx got rdy=%b let=%h want 1/5f", ready, letter); end
        send_rx(8'h20);
        n_checks++; if (ready !== 1'b1) begin n_fail++;
            $display("FAIL play_space_rx got rdy=%b want 1", ready); end
        guess(8'h6C);
        n_checks++;
        if (letter !== 8'h4C || indexCorrect !== 5'b00110 || correct !== 3'd2 ||
            mistake !== 1'b0 || incorrect !== 3'd0) begin n_fail++;
            $display("FAIL guess_L got let=%h idx=%b c=%0d m=%b i=%0d want 4c/00110/2/0/0",
                     letter, indexCorrect, correct, mistake, incorrect); end
        guess(8'h4C);
        n_checks++;
        if (dup !== 1'b1 || indexCorrect !== 5'b0 || correct !== 3'd2 || incorrect !== 3'd0)
            begin n_fail++;
            $display("FAIL dup_L got dup=%b idx=%b c=%0d i=%0d want 1/00000/2/0",
                     dup, indexCorrect, correct, incorrect); end
        step();
        n_checks++; if (dup !== 1'b0 || ready !== 1'b1) begin n_fail++;
            $display("FAIL dup_end got dup=%b rdy=%b want 0/1", dup, ready); end
    endtask

    task automatic test_lose();
        logic [7:0] wrong [6];
        int n;
        wrong = '{8'h51, 8'h5A, 8'h58, 8'h4A, 8'h4B, 8'h56};
        for (int i = 0; i < 6; i++) begin
            guess(wrong[i]);
            n_checks++;
            if (incorrect !== 3'(i + 1) || mistake !== 1'b1 || indexCorrect !== 5'b0) begin
                n_fail++;
                $display("FAIL miss_%0d got i=%0d m=%b idx=%b want %0d/1/00000",
                         i + 1, incorrect, mistake, indexCorrect, i + 1); end
        end
        n_checks++; if (ready !== 1'b0 || correct !== 3'd2) begin n_fail++;
            $display("FAIL lose_entry got rdy=%b c=%0d want 0/2", ready, correct); end
        n = 0;
        while (gameEnd_host !== 1'b1 && n < 50) begin step(); n++; end
        n_checks++; if (gameEnd_host !== 1'b1 || n != END_HOLD) begin n_fail++;
            $display("FAIL lose_hold got end=%b cycles=%0d want 1/%0d", gameEnd_host, n,
                     END_HOLD); end
        n_checks++;
        if (temp_word !== 40'h5F5F5F5F5F || incorrect !== 3'd0 || correct !== 3'd0 ||
            letter !== 8'h5F || mistake !== 1'b0) begin n_fail++;
            $display("FAIL lose_clear got w=%h i=%0d c=%0d l=%h m=%b", temp_word, incorrect,
                     correct, letter, mistake); end
        step();
        n_checks++; if (gameEnd_host !== 1'b0) begin n_fail++;
            $display("FAIL lose_end_pulse got %b want 0", gameEnd_host); end
    endtask

    task automatic test_win();
        logic [7:0] g [4];
        logic [2:0] exp_c [4];
        int n;
        g = '{8'h48, 8'h45, 8'h4C, 8'h4F};
        exp_c = '{3'd1, 3'd2, 3'd4, 3'd5};
        load_word(40'h48454C4C4F);
        send_submit();
        step();
        for (int i = 0; i < 4; i++) begin
            guess(g[i]);
            n_checks++; if (correct !== exp_c[i] || mistake !== 1'b0) begin n_fail++;
                $display("FAIL win_guess_%0d got c=%0d m=%b want %0d/0", i, correct, mistake,
                         exp_c[i]); end
        end
        n_checks++; if (ready !== 1'b0 || indexCorrect !== 5'b00001) begin n_fail++;
            $display("FAIL win_entry got rdy=%b idx=%b want 0/00001", ready, indexCorrect); end
        send_rx(8'h51);
        n = 1;
        n_checks++;
        if (letter !== 8'h4F || incorrect !== 3'd0 || gameEnd_host !== 1'b0) begin n_fail++;
            $display("FAIL win_rx_ignored got l=%h i=%0d end=%b want 4f/0/0", letter,
                     incorrect, gameEnd_host); end
        while (gameEnd_host !== 1'b1 && n < 50) begin step(); n++; end
        n_checks++; if (gameEnd_host !== 1'b1 || n != END_HOLD) begin n_fail++;
            $display("FAIL win_hold got end=%b cycles=%0d want 1/%0d", gameEnd_host, n,
                     END_HOLD); end
        step();
        send_key(8'h61);
        n_checks++; if (setLetter !== 8'h41 || temp_word !== 40'h415F5F5F5F) begin n_fail++;
            $display("FAIL win_back_to_setup got %h/%h want 41/415f5f5f5f", setLetter,
                     temp_word); end
    endtask

    task automatic test_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        n_checks++; if (gameEnd_host !== 1'b1 || setLetter !== 8'h5F) begin n_fail++;
            $display("FAIL restart_setup got end=%b set=%h want 1/5f", gameEnd_host,
                     setLetter); end
        step();
        load_word(40'h48454C4C4F);
        send_submit();
        guess(8'h71);
        n_checks++; if (incorrect !== 3'd1) begin n_fail++;
            $display("FAIL restart_pre got i=%0d want 1", incorrect); end
        rx_letter = 8'h48;
        rx_valid  = 1'b1;
        restart   = 1'b1;
        step();
        rx_valid  = 1'b0;
        restart   = 1'b0;
        n_checks++;
        if (gameEnd_host !== 1'b1 || incorrect !== 3'd0 || correct !== 3'd0 ||
            letter !== 8'h5F || ready !== 1'b0 || temp_word !== 40'h5F5F5F5F5F) begin
            n_fail++;
            $display("FAIL restart_play got end=%b i=%0d c=%0d l=%h rdy=%b w=%h",
                     gameEnd_host, incorrect, correct, letter, ready, temp_word); end
        step();
        n_checks++; if (gameEnd_host !== 1'b0 || correct !== 3'd0 || indexCorrect !== 5'b0)
            begin n_fail++;
            $display("FAIL restart_after got end=%b c=%0d idx=%b want 0/0/0", gameEnd_host,
                     correct, indexCorrect); end
    endtask

    task automatic test_async_reset();
        load_word(40'h48454C4C4F);
        send_submit();
        guess(8'h68);
        n_checks++; if (correct !== 3'd1 || indexCorrect !== 5'b10000) begin n_fail++;
            $display("FAIL areset_pre got c=%0d idx=%b want 1/10000", correct,
                     indexCorrect); end
        #2 nRst = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        nRst = 1'b1;
        step();
    endtask

    initial begin
        nRst = 1'b0; key_valid = 1'b0; key_submit = 1'b0; rx_valid = 1'b0;
        restart = 1'b0; key_letter = 8'h0; rx_letter = 8'h0;
        #12;
        test_reset();
        @(negedge clk);
        nRst = 1'b1;
        step();
        test_setup();
        test_play();
        test_lose();
        test_win();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
